// File: rtl/cgra_fu_pkg.sv
// Shared definitions for the CGRA functional units: add/sub opcode and
// the carry-chain segment width derivation.
package cgra_fu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Guarded so a bad STAGES reaches the elaboration check, not a divide by zero.
  function automatic int unsigned seg_w(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? 1 : width / stages;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// One slice of the segmented carry chain: W-bit add with carry in/out.
module adder_segment #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/seg_adder_pipe.sv
// Pipelined add/sub: the carry chain is cut into STAGES segments, one per
// stage, with the unresolved upper operand bits travelling with each beat.
module seg_adder_pipe
  import cgra_fu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             on_off,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned SEG_W = seg_w(WIDTH, STAGES);
  localparam int unsigned LAST  = STAGES - 1;

  if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("seg_adder_pipe: need STAGES >= 1, WIDTH >= 2, WIDTH %% STAGES == 0");
  end

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] opa_q   [STAGES];
  logic [WIDTH-1:0] opa_d   [STAGES];
  logic [WIDTH-1:0] opb_q   [STAGES];
  logic [WIDTH-1:0] opb_d   [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             cy_q    [STAGES];
  logic             cy_d    [STAGES];
  logic             ovf_q, ovf_d;

  logic             src_v   [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_sum [STAGES];
  logic             src_ci  [STAGES];
  logic [SEG_W-1:0] seg_a   [STAGES];
  logic [SEG_W-1:0] seg_b   [STAGES];
  logic [SEG_W-1:0] seg_s   [STAGES];
  logic             seg_ci  [STAGES];
  logic             seg_co  [STAGES];

  op_e              op_in;
  logic [WIDTH-1:0] b_in;
  logic             ci_in;
  logic             advance;
  logic [WIDTH-1:0] nxt_sum;
  logic             ovf_n;

  always_comb begin
    advance   = on_off && (!valid_q[LAST] || out_ready);
    in_ready  = rst_n && advance;
    out_valid = on_off && valid_q[LAST];
    c         = out_valid ? sum_q[LAST] : '0;
    carry_out = out_valid && cy_q[LAST];
    overflow  = out_valid && ovf_q;
  end

  // Stage k's inputs: the live beat for stage 0, otherwise stage k-1's registers.
  always_comb begin
    op_in      = op_e'(sub);
    b_in       = (op_in == OP_SUB) ? ~b : b;
    ci_in      = (op_in == OP_SUB) ? 1'b1 : carry_in;
    src_v[0]   = in_valid;
    src_a[0]   = a;
    src_b[0]   = b_in;
    src_sum[0] = '0;
    src_ci[0]  = ci_in;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_v[k]   = valid_q[k-1];
      src_a[k]   = opa_q[k-1];
      src_b[k]   = opb_q[k-1];
      src_sum[k] = sum_q[k-1];
      src_ci[k]  = cy_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_a[k]  = src_a[k][k*SEG_W +: SEG_W];
      seg_b[k]  = src_b[k][k*SEG_W +: SEG_W];
      seg_ci[k] = src_ci[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_segment #(.W(SEG_W)) u_seg (
      .a    (seg_a[k]),
      .b    (seg_b[k]),
      .cin  (seg_ci[k]),
      .s    (seg_s[k]),
      .cout (seg_co[k])
    );
  end

  always_comb begin
    nxt_sum = '0;
    ovf_n   = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
              (seg_s[LAST][SEG_W-1] != src_a[LAST][WIDTH-1]);
    ovf_d   = advance ? ovf_n : ovf_q;
    for (int unsigned k = 0; k < STAGES; k++) begin
      nxt_sum                      = src_sum[k];
      nxt_sum[k*SEG_W +: SEG_W]    = seg_s[k];
      valid_d[k] = advance ? src_v[k]  : valid_q[k];
      opa_d[k]   = advance ? src_a[k]  : opa_q[k];
      opb_d[k]   = advance ? src_b[k]  : opb_q[k];
      sum_d[k]   = advance ? nxt_sum   : sum_q[k];
      cy_d[k]    = advance ? seg_co[k] : cy_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        opa_q[k]   <= '0;
        opb_q[k]   <= '0;
        sum_q[k]   <= '0;
        cy_q[k]    <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        opa_q[k]   <= opa_d[k];
        opb_q[k]   <= opb_d[k];
        sum_q[k]   <= sum_d[k];
        cy_q[k]    <= cy_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_seg_adder_pipe.sv
// Randomised bench for seg_adder_pipe against a queue-based reference of
// accepted beats, each aging one step per pipeline advance.
module tb_seg_adder_pipe;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        on_off = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        carry_in = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, carry_out, overflow;
  logic [15:0] c;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] c;
    logic        co;
    logic        ov;
    int          age;
  } beat_t;

  beat_t q[$];

  seg_adder_pipe #(.WIDTH(16), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .on_off    (on_off),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .carry_in  (carry_in),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Returns {overflow, carry_out, c}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic ci);
    logic [15:0] yy;
    logic [16:0] f;
    logic        ov;
    yy = s ? ~y : y;
    f  = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : ci)};
    ov = (x[15] == yy[15]) && (f[15] != x[15]);
    return {ov, f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic        head_out, exp_ov, exp_ir;
    logic [17:0] r;
    beat_t       nb;
    head_out = (q.size() > 0) && (q[0].age == S);
    exp_ov   = rst_n && on_off && head_out;
    exp_ir   = rst_n && on_off && (!head_out || out_ready);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    if (exp_ov) begin
      chk("result", {14'd0, overflow, carry_out, c}, {14'd0, q[0].ov, q[0].co, q[0].c});
    end else begin
      chk("idle_zero", {14'd0, overflow, carry_out, c}, 32'd0);
    end
    if (!rst_n) begin
      q.delete();
    end else if (exp_ir) begin
      if (head_out) void'(q.pop_front());
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (in_valid) begin
        r      = model(a, b, sub, carry_in);
        nb.c   = r[15:0];
        nb.co  = r[16];
        nb.ov  = r[17];
        nb.age = 1;
        q.push_back(nb);
      end
    end
  end

  task automatic beat(input logic v, input logic [15:0] x, input logic [15:0] y,
                      input logic s, input logic ci, input logic on, input logic rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = x;
    b         = y;
    sub       = s;
    carry_in  = ci;
    on_off    = on;
    out_ready = rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic rnd_beat(input logic on, input logic rdy);
    beat(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), on, rdy);
  endtask

  initial begin
    chk("pin_ffff_add", {14'd0, model(16'hFFFF, 16'h0001, 1'b0, 1'b0)}, {14'd0, 1'b0, 1'b1, 16'h0000});
    chk("pin_7fff_add", {14'd0, model(16'h7FFF, 16'h0001, 1'b0, 1'b0)}, {14'd0, 1'b1, 1'b0, 16'h8000});
    chk("pin_3m5_sub",  {14'd0, model(16'h0003, 16'h0005, 1'b1, 1'b1)}, {14'd0, 1'b0, 1'b0, 16'hFFFE});
    chk("pin_5m3_sub",  {14'd0, model(16'h0005, 16'h0003, 1'b1, 1'b0)}, {14'd0, 1'b0, 1'b1, 16'h0002});
    chk("pin_8000m1",   {14'd0, model(16'h8000, 16'h0001, 1'b1, 1'b0)}, {14'd0, 1'b1, 1'b1, 16'h7FFF});
    chk("pin_cin",      {14'd0, model(16'h0001, 16'h0001, 1'b0, 1'b1)}, {14'd0, 1'b0, 1'b0, 16'h0003});

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    on_off = 1'b1;
    out_ready = 1'b1;

    beat(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    repeat (3) @(posedge clk);
    #1;
    chk("lit_ffff", {13'd0, out_valid, carry_out, overflow, c}, {13'd0, 1'b1, 1'b1, 1'b0, 16'h0000});
    idle(4);

    beat(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1);
    repeat (2) @(posedge clk);
    #1;
    chk("lit_7fff", {13'd0, out_valid, carry_out, overflow, c}, {13'd0, 1'b1, 1'b0, 1'b1, 16'h8000});
    @(posedge clk);
    #1;
    chk("lit_sub", {13'd0, out_valid, carry_out, overflow, c}, {13'd0, 1'b1, 1'b0, 1'b0, 16'hFFFE});
    idle(4);

    for (int i = 0; i < 8; i++) rnd_beat(1'b1, 1'b1);
    idle(6);

    for (int i = 0; i < 4; i++) rnd_beat(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) rnd_beat(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) rnd_beat(1'b1, 1'b1);
    idle(8);

    for (int i = 0; i < 3; i++) rnd_beat(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) rnd_beat(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) rnd_beat(1'b1, 1'b1);
    idle(8);

    for (int i = 0; i < 5; i++) rnd_beat(1'b1, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_rst", {14'd0, out_valid, carry_out, overflow, c[12:0]}, 32'd0);
    chk("async_rst_c", {16'd0, c}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rnd_beat(1'b1, 1'b1);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      beat(1'($urandom), (($urandom % 4) == 0) ? 16'hFFFF : 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), (($urandom % 8) != 0), (($urandom % 4) != 0));
    end
    idle(12);
    chk("drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_adder_pipe.md
SEG_ADDER_PIPE -- requirements
Module: seg_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth. Carry chain is split into STAGES segments of WIDTH/STAGES bits each.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port on_off, input, 1: unit enable (1 = on).
REQ-006 SHALL have port in_valid, input, 1: operand beat is valid.
REQ-007 SHALL have port in_ready, output, 1: unit accepts a beat this cycle.
REQ-008 SHALL have port sub, input, 1: 0 = add, 1 = subtract; sampled with the beat.
REQ-009 SHALL have port carry_in, input, 1: carry into bit 0 for add; ignored for sub.
REQ-010 SHALL have ports a and b, input, WIDTH each: operands.
REQ-011 SHALL have port out_valid, output, 1: result beat is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port c, output, WIDTH: sum/difference.
REQ-014 SHALL have port carry_out, output, 1: carry from the MSB; for sub, 1 means no borrow.
REQ-015 SHALL have port overflow, output, 1: two's-complement signed overflow.

Function
REQ-016 SHALL elaborate-time fail unless WIDTH % STAGES == 0, STAGES >= 1 and WIDTH >= 2.
REQ-017 SHALL compute add as {carry_out, c} = a + b + carry_in, modulo 2^(WIDTH+1).
REQ-018 SHALL compute sub as {carry_out, c} = a + ~b + 1.
REQ-019 SHALL set overflow = (opA[MSB] == opB'[MSB]) && (c[MSB] != opA[MSB]), where opB' is b after the sub inversion.
REQ-020 SHALL have stage k (k = 0..STAGES-1) resolve segment k using the registered carry from stage k-1.
REQ-021 SHALL carry unresolved upper operand segments forward alongside each beat, skewed by stage.
REQ-022 SHALL have a fixed latency of STAGES cycles from acceptance (in_valid && in_ready) to out_valid, absent stalls.
REQ-023 SHALL sustain one beat per cycle when out_ready is held at 1.
REQ-024 SHALL define in_ready = on_off && (!stage_last_valid || out_ready). The whole pipeline advances or stalls as one.
REQ-025 SHALL hold every stage and the output stable while out_valid && !out_ready (no beat lost or duplicated).
REQ-026 SHALL insert a bubble (valid = 0) into stage 0 on an advancing cycle when in_valid = 0.
REQ-027 SHALL, when on_off = 0:
  - drive in_ready = 0 and out_valid = 0;
  - drive c, carry_out and overflow to 0;
  - freeze pipeline contents.
  When on_off returns to 1, frozen beats resume in order.
REQ-028 SHALL drive c, carry_out and overflow to 0 whenever out_valid = 0.
REQ-029 SHALL process on_off and out_ready changing in the same cycle using the values present in that cycle only.

Reset
REQ-030 SHALL, on rst_n low, immediately clear all stage valid bits and data registers, independent of clk.
REQ-031 SHALL drive out_valid = 0, c = 0, carry_out = 0, overflow = 0 during reset; in_ready = 0 while rst_n = 0.
REQ-032 SHALL discard in-flight beats on reset mid-operation; the first accepted beat after release appears STAGES cycles later.

Structure
REQ-033 SHALL place the add/sub op encoding typedef and a SEG_W derivation helper in shared package cgra_fu_pkg.
REQ-034 SHALL instantiate one sub-module per stage, adder_segment: combinational SEG_W-bit add with carry in/out.

Verification
All scenarios use WIDTH = 16, STAGES = 4.
REQ-035 Bench SHALL cover: a = 0xFFFF, b = 0x0001, add, carry_in = 0 -> after 4 cycles, c = 0x0000, carry_out = 1, overflow = 0.
REQ-036 Bench SHALL cover: a = 0x7FFF, b = 0x0001, add -> c = 0x8000, overflow = 1, carry_out = 0; then sub with a = 0x0003, b = 0x0005 -> c = 0xFFFE, carry_out = 0.
REQ-037 Bench SHALL cover: 8 back-to-back beats with out_ready = 1 -> 8 results on consecutive cycles 4..11, in order.
REQ-038 Bench SHALL cover: out_ready = 0 for 3 cycles while pipeline full -> in_ready = 0, c held constant, no beat dropped after release.
REQ-039 Bench SHALL cover: on_off = 0 for 2 cycles mid-stream -> out_valid = 0, c = 0; stream resumes intact with unchanged ordering.
REQ-040 Bench SHALL cover: rst_n asserted asynchronously with 3 beats in flight -> out_valid drops immediately; no stale result after release.
